// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared types for the fetch/data bus arbiter
package bus_arbiter_pkg;
   typedef enum logic [1:0] {ARB_IDLE, ARB_DATA, ARB_INST} arb_state_t;
   typedef logic [3:0]  bus_sel_t;
   typedef logic [31:0] reg_t;
   typedef logic [31:0] inst_addr_t;
   localparam bus_sel_t SEL_ALL = 4'b1111;
endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: fetch port, data port and external bus signals of the arbiter
interface bus_arbiter_if;
   import bus_arbiter_pkg::*;
   logic       if_ce;
   inst_addr_t if_addr;
   reg_t       if_rdata;
   logic       if_ready;
   logic       dm_ce;
   logic       dm_we;
   bus_sel_t   dm_sel;
   reg_t       dm_addr;
   reg_t       dm_wdata;
   reg_t       dm_rdata;
   logic       dm_ready;
   logic       bus_req;
   logic       bus_we;
   bus_sel_t   bus_sel;
   reg_t       bus_addr;
   reg_t       bus_wdata;
   reg_t       bus_rdata;
   logic       bus_ack;
   logic       stallreq;
   logic       err;
   modport master (
      input  if_ce, if_addr, dm_ce, dm_we, dm_sel, dm_addr, dm_wdata, bus_rdata, bus_ack,
      output if_rdata, if_ready, dm_rdata, dm_ready, bus_req, bus_we, bus_sel, bus_addr,
             bus_wdata, stallreq, err
   );
   modport slave (
      output if_ce, if_addr, dm_ce, dm_we, dm_sel, dm_addr, dm_wdata, bus_rdata, bus_ack,
      input  if_rdata, if_ready, dm_rdata, dm_ready, bus_req, bus_we, bus_sel, bus_addr,
             bus_wdata, stallreq, err
   );
endinterface

// File: rtl/bus_arbiter_watchdog.sv
// bus_arbiter_watchdog: saturating wait counter that flags a missing bus ack
module bus_arbiter_watchdog #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic run,
   output logic expired
);
   logic [CNT_W-1:0] cnt;
   // fires in the cycle whose increment would reach TIMEOUT, so the access completes on that edge
   assign expired = (TIMEOUT != 0) && run && (int'(cnt) >= TIMEOUT - 1);
   always_ff @(posedge clk)
      if (rst || clr) cnt <= '0;
      else if (run && int'(cnt) < TIMEOUT) cnt <= cnt + 1'b1;
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one SRAM-like bus between instruction fetch and data access, data first
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input logic           clk,
   input logic           rst,
   bus_arbiter_if.master bus
);
   arb_state_t state;
   logic if_done, dm_done, busy, ack, expired, grant_dm, grant_if;
   assign busy         = state != ARB_IDLE;
   assign ack          = busy && bus.bus_ack;
   assign bus.stallreq = (bus.dm_ce & ~dm_done) | (bus.if_ce & ~if_done);
   assign bus.if_ready = if_done;
   assign bus.dm_ready = dm_done;
   assign grant_dm     = state == ARB_IDLE && bus.dm_ce && !dm_done;
   assign grant_if     = state == ARB_IDLE && !grant_dm && bus.if_ce && !if_done;
   bus_arbiter_watchdog #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_watchdog (
      .clk(clk),
      .rst(rst),
      .clr(grant_dm || grant_if),
      .run(busy && !bus.bus_ack),
      .expired(expired)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ARB_IDLE;
         if_done       <= 1'b0;
         dm_done       <= 1'b0;
         bus.bus_req   <= 1'b0;
         bus.bus_we    <= 1'b0;
         bus.bus_sel   <= '0;
         bus.bus_addr  <= '0;
         bus.bus_wdata <= '0;
         bus.if_rdata  <= '0;
         bus.dm_rdata  <= '0;
         bus.err       <= 1'b0;
      end else begin
         if (!bus.stallreq) begin
            if_done <= 1'b0;
            dm_done <= 1'b0;
         end
         if (grant_dm || grant_if) begin
            state         <= grant_dm ? ARB_DATA : ARB_INST;
            bus.bus_req   <= 1'b1;
            bus.bus_we    <= grant_dm && bus.dm_we;
            bus.bus_sel   <= grant_dm ? bus.dm_sel : SEL_ALL;
            bus.bus_addr  <= grant_dm ? bus.dm_addr : bus.if_addr;
            bus.bus_wdata <= grant_dm ? bus.dm_wdata : '0;
         end
         // a requester that dropped ce mid-access gets no result
         if (ack || expired) begin
            state       <= ARB_IDLE;
            bus.bus_req <= 1'b0;
            if (expired) bus.err <= 1'b1;
            if (state == ARB_DATA && bus.dm_ce) begin
               dm_done      <= 1'b1;
               bus.dm_rdata <= (ack && !bus.bus_we) ? bus.bus_rdata : '0;
            end
            if (state == ARB_INST && bus.if_ce) begin
               if_done      <= 1'b1;
               bus.if_rdata <= ack ? bus.bus_rdata : '0;
            end
         end
      end
   end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: randomized scoreboard bench with a bus slave model and result monitor
module tb_bus_arbiter;
   import bus_arbiter_pkg::*;
   localparam int TIMEOUT = 4;
   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] wdata;
      int          delay;
   } acc_t;
   typedef struct {
      logic [31:0] rdata;
      logic        timeout;
   } res_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic force_ack = 1'b0;
   logic err_exp = 1'b0;
   int checks = 0;
   int fails = 0;
   acc_t acc_q[$];
   res_t if_q[$];
   res_t dm_q[$];
   always #5 clk = ~clk;
   bus_arbiter_if bus();
   bus_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));
   function automatic logic [31:0] mem(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic check_idle(input string t);
      check({t, "_bus_req"}, 32'(bus.bus_req), 32'h0);
      check({t, "_bus_we"}, 32'(bus.bus_we), 32'h0);
      check({t, "_bus_sel"}, 32'(bus.bus_sel), 32'h0);
      check({t, "_bus_addr"}, bus.bus_addr, 32'h0);
      check({t, "_bus_wdata"}, bus.bus_wdata, 32'h0);
      check({t, "_if_ready"}, 32'(bus.if_ready), 32'h0);
      check({t, "_dm_ready"}, 32'(bus.dm_ready), 32'h0);
      check({t, "_if_rdata"}, bus.if_rdata, 32'h0);
      check({t, "_dm_rdata"}, bus.dm_rdata, 32'h0);
      check({t, "_err"}, 32'(bus.err), 32'h0);
      check({t, "_stallreq"}, 32'(bus.stallreq), 32'h0);
   endtask
   task automatic issue_dm(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                           input logic [31:0] wdata, input int delay, input bit keep);
      bit tmo = delay + 1 > TIMEOUT;
      bus.dm_ce = 1'b1;
      bus.dm_we = we;
      bus.dm_sel = sel;
      bus.dm_addr = addr;
      bus.dm_wdata = wdata;
      acc_q.push_back('{addr, we, sel, wdata, delay});
      if (keep) dm_q.push_back('{(we || tmo) ? 32'h0 : mem(addr), tmo});
   endtask
   task automatic issue_if(input logic [31:0] addr, input int delay);
      bit tmo = delay + 1 > TIMEOUT;
      bus.if_ce = 1'b1;
      bus.if_addr = addr;
      acc_q.push_back('{addr, 1'b0, 4'b1111, 32'h0, delay});
      if_q.push_back('{tmo ? 32'h0 : mem(addr), tmo});
   endtask
   task automatic wait_release();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.stallreq && n < 60);
      if (bus.stallreq) begin
         checks++;
         fails++;
         $display("FAIL stall_release: stallreq still 1 after %0d cycles, expected 0", n);
      end
      @(posedge clk);
      #1;
      bus.dm_ce = 1'b0;
      bus.if_ce = 1'b0;
   endtask
   task automatic wait_req(input logic lvl);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.bus_req !== lvl && n < 30);
      if (bus.bus_req !== lvl) begin
         checks++;
         fails++;
         $display("FAIL bus_req_wait: got %b expected %b", bus.bus_req, lvl);
      end
   endtask
   initial begin : slave
      acc_t a;
      int k;
      bit active;
      active = 0;
      k = 0;
      bus.bus_ack = 1'b0;
      bus.bus_rdata = '0;
      forever begin
         @(negedge clk);
         bus.bus_ack = force_ack;
         bus.bus_rdata = $urandom;
         if (rst) active = 0;
         else if (bus.bus_req) begin
            if (!active) begin
               active = 1;
               k = 0;
               if (acc_q.size() == 0) begin
                  checks++;
                  fails++;
                  $display("FAIL bus_req_unexpected: got access to %0h, expected none", bus.bus_addr);
                  a = '{bus.bus_addr, bus.bus_we, bus.bus_sel, bus.bus_wdata, 99};
               end else a = acc_q.pop_front();
            end
            check("bus_addr", bus.bus_addr, a.addr);
            check("bus_we", 32'(bus.bus_we), 32'(a.we));
            check("bus_sel", 32'(bus.bus_sel), 32'(a.sel));
            check("bus_wdata", bus.bus_wdata, a.wdata);
            k++;
            if (k == a.delay + 1) begin
               bus.bus_ack = 1'b1;
               bus.bus_rdata = mem(a.addr);
            end
         end else if (active) begin
            active = 0;
            check("bus_req_len", 32'(k), 32'((a.delay + 1 <= TIMEOUT) ? a.delay + 1 : TIMEOUT));
         end
      end
   end
   initial begin : monitor
      logic pif, pdm;
      res_t r;
      pif = 1'b0;
      pdm = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            err_exp = 1'b0;
            pif = 1'b0;
            pdm = 1'b0;
         end else begin
            if (bus.dm_ready && !pdm) begin
               if (dm_q.size() == 0) begin
                  checks++;
                  fails++;
                  $display("FAIL dm_ready_unexpected: got ready rdata %0h, expected no ready", bus.dm_rdata);
               end else begin
                  r = dm_q.pop_front();
                  err_exp |= r.timeout;
                  check("dm_rdata", bus.dm_rdata, r.rdata);
               end
            end
            if (bus.if_ready && !pif) begin
               if (if_q.size() == 0) begin
                  checks++;
                  fails++;
                  $display("FAIL if_ready_unexpected: got ready rdata %0h, expected no ready", bus.if_rdata);
               end else begin
                  r = if_q.pop_front();
                  err_exp |= r.timeout;
                  check("if_rdata", bus.if_rdata, r.rdata);
               end
            end
            if (pdm && !bus.dm_ready) check("clear_together_if", 32'(bus.if_ready), 32'h0);
            if (pif && !bus.if_ready) check("clear_together_dm", 32'(bus.dm_ready), 32'h0);
            check("err", 32'(bus.err), 32'(err_exp));
            check("stallreq", 32'(bus.stallreq),
                  32'((bus.dm_ce && !bus.dm_ready) || (bus.if_ce && !bus.if_ready)));
            pif = bus.if_ready;
            pdm = bus.dm_ready;
         end
      end
   end
   initial begin : driver
      int mode;
      bus.if_ce = 1'b0;
      bus.if_addr = '0;
      bus.dm_ce = 1'b0;
      bus.dm_we = 1'b0;
      bus.dm_sel = '0;
      bus.dm_addr = '0;
      bus.dm_wdata = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_idle("reset");
      // ack strobe with nothing in flight must be ignored
      @(posedge clk);
      #1 force_ack = 1'b1;
      @(posedge clk);
      #1 force_ack = 1'b0;
      @(negedge clk);
      check_idle("idle_ack");
      @(posedge clk);
      #1;
      issue_if(32'h100, 2);
      wait_release();
      issue_dm(1'b0, 4'b1111, 32'h2000, 32'h0, 1, 1);
      issue_if(32'h104, 1);
      wait_release();
      issue_dm(1'b1, 4'b0011, 32'h40, 32'hDEAD_BEEF, 3, 1);
      wait_release();
      issue_if(32'h108, 5);
      wait_release();
      for (int r = 0; r < 80; r++) begin
         mode = int'($urandom_range(0, 4));
         if (mode == 0 || mode == 2)
            issue_dm(1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), $urandom, $urandom,
                     int'($urandom_range(0, 5)), 1);
         if (mode == 1 || mode == 2) issue_if($urandom, int'($urandom_range(0, 5)));
         if (mode <= 2) wait_release();
         else if (mode == 3) begin
            issue_dm(1'b0, 4'b1111, $urandom, 32'h0, int'($urandom_range(2, 3)), 0);
            wait_req(1'b1);
            @(posedge clk);
            #1 bus.dm_ce = 1'b0;
            wait_req(1'b0);
            @(posedge clk);
            #1;
         end else begin
            @(posedge clk);
            #1;
         end
      end
      // reset in the second cycle of a data access, then a stray ack
      issue_dm(1'b0, 4'b1111, 32'h3000, 32'h0, 2, 0);
      wait_req(1'b1);
      @(posedge clk);
      #1 rst = 1'b1;
      bus.dm_ce = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      force_ack = 1'b1;
      @(negedge clk);
      check("rst_bus_req", 32'(bus.bus_req), 32'h0);
      @(posedge clk);
      #1 force_ack = 1'b0;
      @(negedge clk);
      check_idle("after_rst");
      check("queues_drained", 32'(acc_q.size() + if_q.size() + dm_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
